// File: rtl/csi_rx_sequencer.sv
// ============================================================================
// Module   : csi_rx_sequencer
// Purpose  : Control FSM for the CSI receive chain (trigger -> short sync ->
//            long sync/FFT/equalizer -> holdoff) with saturating statistics.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module csi_rx_sequencer #(
  parameter int SHORT_TIMEOUT = 480,
  parameter int LONG_TIMEOUT  = 320,
  parameter int HOLDOFF_LEN   = 200,
  parameter int CNT_W         = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic             sample_valid_in,
  input  logic             power_trigger_in,
  input  logic             short_detected_in,
  input  logic             csi_tvalid_in,
  input  logic             csi_tready_in,
  input  logic             csi_tlast_in,
  input  logic             stats_clr_in,
  output logic             sync_short_rst_out,
  output logic             sync_long_rst_out,
  output logic             short_en_out,
  output logic             long_en_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] pkt_cnt_out,
  output logic [CNT_W-1:0] short_to_cnt_out,
  output logic [CNT_W-1:0] long_to_cnt_out
);

  localparam int c_MAX_A   = (SHORT_TIMEOUT > LONG_TIMEOUT) ? SHORT_TIMEOUT : LONG_TIMEOUT;
  localparam int c_MAX_LEN = (c_MAX_A > HOLDOFF_LEN) ? c_MAX_A : HOLDOFF_LEN;
  localparam int c_SMP_W   = $clog2(c_MAX_LEN + 1);

  localparam logic [c_SMP_W-1:0] c_SHORT_LAST = c_SMP_W'(SHORT_TIMEOUT - 1);
  localparam logic [c_SMP_W-1:0] c_LONG_LAST  = c_SMP_W'(LONG_TIMEOUT - 1);
  localparam logic [c_SMP_W-1:0] c_HOLD_LAST  = c_SMP_W'(HOLDOFF_LEN - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SYNC_SHORT = 2'd1,
    ST_SYNC_LONG  = 2'd2,
    ST_HOLDOFF    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_SMP_W-1:0]  r_smp_cnt;
  logic                r_short_rst;
  logic                r_long_rst;
  logic                r_short_en;
  logic                r_long_en;
  logic [CNT_W-1:0]    r_pkt_cnt;
  logic [CNT_W-1:0]    r_sto_cnt;
  logic [CNT_W-1:0]    r_lto_cnt;

  logic                w_short_rst_nxt;
  logic                w_long_rst_nxt;
  logic                w_counted;
  logic                w_handshake;
  logic                w_pkt_inc;
  logic                w_sto_inc;
  logic                w_lto_inc;

  // Only samples that actually reach an enabled stage advance the sample count.
  assign w_counted = sample_valid_in &&
                     (((r_state == ST_SYNC_SHORT) && r_short_en) ||
                      ((r_state == ST_SYNC_LONG)  && r_long_en)  ||
                       (r_state == ST_HOLDOFF));

  assign w_handshake = csi_tvalid_in && csi_tready_in && csi_tlast_in;

  always_comb begin
    w_state_nxt     = r_state;
    w_short_rst_nxt = 1'b0;
    w_long_rst_nxt  = 1'b0;
    w_pkt_inc       = 1'b0;
    w_sto_inc       = 1'b0;
    w_lto_inc       = 1'b0;
    if (!enable_in) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (power_trigger_in) begin
            w_state_nxt     = ST_SYNC_SHORT;
            w_short_rst_nxt = 1'b1;
          end
        end
        ST_SYNC_SHORT: begin
          if (short_detected_in) begin
            w_state_nxt    = ST_SYNC_LONG;
            w_long_rst_nxt = 1'b1;
          end else if (!power_trigger_in) begin
            w_state_nxt = ST_IDLE;
          end else if (w_counted && (r_smp_cnt == c_SHORT_LAST)) begin
            w_state_nxt = ST_HOLDOFF;
            w_sto_inc   = 1'b1;
          end
        end
        ST_SYNC_LONG: begin
          // Power level is ignored here: FFT latency can outlast the burst.
          if (w_handshake) begin
            w_state_nxt = ST_HOLDOFF;
            w_pkt_inc   = 1'b1;
          end else if (w_counted && (r_smp_cnt == c_LONG_LAST)) begin
            w_state_nxt = ST_HOLDOFF;
            w_lto_inc   = 1'b1;
          end
        end
        default: begin
          if (w_counted && (r_smp_cnt == c_HOLD_LAST)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_smp_cnt   <= '0;
      r_short_rst <= 1'b0;
      r_long_rst  <= 1'b0;
      r_short_en  <= 1'b0;
      r_long_en   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_short_rst <= w_short_rst_nxt;
      r_long_rst  <= w_long_rst_nxt;
      r_short_en  <= (w_state_nxt == ST_SYNC_SHORT) && !w_short_rst_nxt;
      r_long_en   <= (w_state_nxt == ST_SYNC_LONG)  && !w_long_rst_nxt;
      if (w_state_nxt != r_state) begin
        r_smp_cnt <= '0;
      end else if (w_counted) begin
        r_smp_cnt <= r_smp_cnt + 1'b1;
      end
    end
  end

  // Statistics: a clear pulse wins over a same-cycle increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pkt_cnt <= '0;
      r_sto_cnt <= '0;
      r_lto_cnt <= '0;
    end else if (stats_clr_in) begin
      r_pkt_cnt <= '0;
      r_sto_cnt <= '0;
      r_lto_cnt <= '0;
    end else begin
      if (w_pkt_inc && (r_pkt_cnt != c_CNT_MAX)) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_sto_inc && (r_sto_cnt != c_CNT_MAX)) r_sto_cnt <= r_sto_cnt + 1'b1;
      if (w_lto_inc && (r_lto_cnt != c_CNT_MAX)) r_lto_cnt <= r_lto_cnt + 1'b1;
    end
  end

  assign state_out          = r_state;
  assign sync_short_rst_out = r_short_rst;
  assign sync_long_rst_out  = r_long_rst;
  assign short_en_out       = r_short_en;
  assign long_en_out        = r_long_en;
  assign pkt_cnt_out        = r_pkt_cnt;
  assign short_to_cnt_out   = r_sto_cnt;
  assign long_to_cnt_out    = r_lto_cnt;

endmodule

`default_nettype wire
